// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one async_transmitter among
// NUM_REQ byte-stream requesters. A grant is held until a byte flagged
// last has been sent (or an idle lock times out). tx_start is paced
// against tx_busy, and busy is ignored for GUARD_CYCLES after a start
// because the transmitter raises it late.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int ID_W         = 2,
  parameter int GUARD_CYCLES = 1,
  parameter int LOCK_TIMEOUT = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 tx_start,
  output logic [7:0]           tx_data,
  input  logic                 tx_busy,
  output logic                 grant_active,
  output logic [ID_W-1:0]      grant_id,
  output logic                 timeout_evt
);

  localparam int CNT_W = 16;

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GUARD, S_WAIT} state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]   gid_q, gid_d;
  logic              gact_q, gact_d;
  logic              last_q, last_d;
  logic              tx_start_q, tx_start_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              tmo_q, tmo_d;
  logic [CNT_W-1:0]  guard_cnt_q, guard_cnt_d;
  logic [CNT_W-1:0]  idle_cnt_q, idle_cnt_d;

  logic              pick_found;
  logic [ID_W-1:0]   pick_id;
  logic [ID_W-1:0]   cand;
  logic              hs;

  // Round-robin scan starting at rr_ptr; first valid requester wins.
  always_comb begin
    pick_found = 1'b0;
    pick_id    = rr_ptr_q;
    cand       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = ID_W'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (!pick_found && req_valid[cand]) begin
        pick_found = 1'b1;
        pick_id    = cand;
      end
    end
  end

  // Next-state and outputs; the owner is only offered ready in SEND.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    gid_d       = gid_q;
    gact_d      = gact_q;
    last_d      = last_q;
    tx_start_d  = 1'b0;
    tx_data_d   = tx_data_q;
    tmo_d       = 1'b0;
    guard_cnt_d = guard_cnt_q;
    idle_cnt_d  = idle_cnt_q;
    req_ready   = '0;
    hs          = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          gid_d      = pick_id;
          gact_d     = 1'b1;
          idle_cnt_d = '0;
          state_d    = S_SEND;
        end
      end
      S_SEND: begin
        hs               = req_valid[gid_q] & ~tx_busy;
        req_ready[gid_q] = hs;
        if (hs) begin
          tx_start_d  = 1'b1;
          tx_data_d   = req_data[8*gid_q +: 8];
          last_d      = req_last[gid_q];
          guard_cnt_d = '0;
          idle_cnt_d  = '0;
          state_d     = S_GUARD;
        end else if (LOCK_TIMEOUT > 0 && !req_valid[gid_q]) begin
          if (idle_cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
            tmo_d    = 1'b1;
            gact_d   = 1'b0;
            rr_ptr_d = ID_W'((int'(gid_q) + 1) % NUM_REQ);
            state_d  = S_IDLE;
          end else begin
            idle_cnt_d = idle_cnt_q + 16'd1;
          end
        end
      end
      S_GUARD: begin
        if (guard_cnt_q == CNT_W'(GUARD_CYCLES - 1)) begin
          guard_cnt_d = '0;
          state_d     = S_WAIT;
        end else begin
          guard_cnt_d = guard_cnt_q + 16'd1;
        end
      end
      S_WAIT: begin
        if (!tx_busy) begin
          if (last_q) begin
            gact_d   = 1'b0;
            rr_ptr_d = ID_W'((int'(gid_q) + 1) % NUM_REQ);
            state_d  = S_IDLE;
          end else begin
            state_d = S_SEND;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset drops any lock immediately.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= '0;
      gid_q       <= '0;
      gact_q      <= 1'b0;
      last_q      <= 1'b0;
      tx_start_q  <= 1'b0;
      tx_data_q   <= 8'h00;
      tmo_q       <= 1'b0;
      guard_cnt_q <= '0;
      idle_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      gid_q       <= gid_d;
      gact_q      <= gact_d;
      last_q      <= last_d;
      tx_start_q  <= tx_start_d;
      tx_data_q   <= tx_data_d;
      tmo_q       <= tmo_d;
      guard_cnt_q <= guard_cnt_d;
      idle_cnt_q  <= idle_cnt_d;
    end
  end

  assign tx_start     = tx_start_q;
  assign tx_data      = tx_data_q;
  assign grant_active = gact_q;
  assign grant_id     = gid_q;
  assign timeout_evt  = tmo_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: requester byte queues, a UART busy model,
// and a packet-level round-robin model predicting the transmitted stream.
module tb_uart_tx_arbiter;
  localparam int NR = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [NR-1:0] req_valid, req_last, req_ready;
  logic [8*NR-1:0] req_data;
  logic          tx_start, tx_busy, grant_active, timeout_evt;
  logic [7:0]    tx_data;
  logic [1:0]    grant_id;

  uart_tx_arbiter #(.NUM_REQ(NR), .ID_W(2), .GUARD_CYCLES(1), .LOCK_TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .tx_start(tx_start),
    .tx_data(tx_data), .tx_busy(tx_busy), .grant_active(grant_active),
    .grant_id(grant_id), .timeout_evt(timeout_evt)
  );

  always #5 clk = ~clk;

  // transmitter model: busy rises the cycle after a start, lasts frame cycles
  int frame = 10;
  int busy_cnt = 0;
  always @(posedge clk) begin
    if (tx_start) busy_cnt <= frame;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end
  assign tx_busy = (busy_cnt != 0);

  int n_chk = 0, n_pass = 0;
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    else n_pass++;
  endtask

  // requester byte queues {last,data}
  logic [8:0] mem [NR][64];
  int hd [NR];
  int tl [NR];
  logic [9:0] expq [$];   // {id, data}
  int m_ptr = 0;

  // monitor state
  int cyc = 0, last_start = -1, rdy_cnt = 0, evt_cnt = 0, evt_cyc = 0;
  logic hs_prev = 1'b0;
  logic [7:0] hs_byte = 8'h00;
  logic [NR-1:0] smp_ready;
  logic smp_gact, smp_start, smp_tmo;
  logic [7:0] smp_data;
  logic [1:0] smp_gid;

  task automatic load(input int i, input logic [7:0] d, input logic l);
    if (hd[i] == tl[i]) begin hd[i] = 0; tl[i] = 0; end
    mem[i][tl[i]] = {l, d};
    tl[i]++;
  endtask

  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      req_valid[i] = (hd[i] < tl[i]);
      req_data[8*i +: 8] = (hd[i] < tl[i]) ? mem[i][hd[i]][7:0] : 8'h00;
      req_last[i] = (hd[i] < tl[i]) ? mem[i][hd[i]][8] : 1'b0;
    end
  endtask

  function automatic bit queues_empty();
    bit e = 1'b1;
    for (int i = 0; i < NR; i++) if (hd[i] < tl[i]) e = 1'b0;
    return e;
  endfunction

  // Expected stream: whole packets, owner chosen round-robin among
  // requesters that still have data, pointer moves past each owner.
  function automatic void build_exp();
    int pos [NR];
    int g;
    logic lst;
    bit done = 1'b0;
    for (int i = 0; i < NR; i++) pos[i] = hd[i];
    while (!done) begin
      g = -1;
      for (int k = 0; k < NR; k++) begin
        int j = (m_ptr + k) % NR;
        if (g < 0 && pos[j] < tl[j]) g = j;
      end
      if (g < 0) done = 1'b1;
      else begin
        lst = 1'b0;
        while (!lst && pos[g] < tl[g]) begin
          expq.push_back({g[1:0], mem[g][pos[g]][7:0]});
          lst = mem[g][pos[g]][8];
          pos[g]++;
        end
        m_ptr = (g + 1) % NR;
      end
    end
  endfunction

  // one clock: sample/check at negedge, advance requesters after posedge
  task automatic step();
    logic [NR-1:0] hs, own;
    logic [9:0] e;
    @(negedge clk);
    cyc++;
    smp_ready = req_ready; smp_gact = grant_active; smp_start = tx_start;
    smp_data = tx_data; smp_gid = grant_id; smp_tmo = timeout_evt;
    hs = req_valid & req_ready;
    if (hs_prev) begin
      chk("hs_to_start", tx_start, 1'b1);
      chk("hs_to_data", tx_data, hs_byte);
    end
    if (tx_start) begin
      chk("start_nobusy", tx_busy, 1'b0);
      if (last_start >= 0) chk("start_gap", (cyc - last_start) > frame, 1'b1);
      last_start = cyc;
      rdy_cnt = 0;
      chk("exp_avail", expq.size() > 0, 1'b1);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("order_id", grant_id, e[9:8]);
        chk("order_data", tx_data, e[7:0]);
      end
    end
    if (req_ready != 0) begin
      own = smp_gact ? (4'b0001 << grant_id) : 4'b0000;
      chk("rdy_onehot", $countones(req_ready), 1);
      chk("rdy_owner", req_ready & ~own, 0);
      chk("rdy_nobusy", tx_busy, 1'b0);
    end
    hs_prev = 1'b0;
    if (hs != 0) begin
      chk("rdy_once", rdy_cnt, 0);
      rdy_cnt++;
      hs_prev = 1'b1;
      for (int i = 0; i < NR; i++) if (hs[i]) hs_byte = req_data[8*i +: 8];
    end
    if (timeout_evt) begin evt_cnt++; evt_cyc = cyc; end
    @(posedge clk);
    #1;
    for (int i = 0; i < NR; i++) if (hs[i]) hd[i]++;
    drive();
  endtask

  task automatic drain(input int budget);
    int n = 0;
    step();
    while ((expq.size() != 0 || smp_gact || tx_busy || !queues_empty()) && n < budget) begin
      step();
      n++;
    end
    chk("drain_bound", n < budget, 1'b1);
  endtask

  initial begin
    int n, e0, s3, nb;
    reset = 1'b1; req_valid = '0; req_data = '0; req_last = '0;
    for (int i = 0; i < NR; i++) begin hd[i] = 0; tl[i] = 0; end
    repeat (3) step();
    chk("rst_start", smp_start, 1'b0);
    chk("rst_data", smp_data, 8'h00);
    chk("rst_gact", smp_gact, 1'b0);
    chk("rst_gid", smp_gid, 2'd0);
    chk("rst_tmo", smp_tmo, 1'b0);
    chk("rst_ready", smp_ready, 4'b0000);
    reset = 1'b0;

    // single byte: grant cycle, ready cycle, start cycle
    load(0, 8'hA5, 1'b1); build_exp(); drive();
    step();
    chk("t1_idle_ready", smp_ready, 4'b0000);
    chk("t1_idle_gact", smp_gact, 1'b0);
    step();
    chk("t1_ready", smp_ready, 4'b0001);
    chk("t1_gact", smp_gact, 1'b1);
    step();
    chk("t1_start", smp_start, 1'b1);
    chk("t1_data", smp_data, 8'hA5);
    drain(100);
    chk("t1_released", smp_gact, 1'b0);

    // packet lock: req1 11,22,33 while req2 waits
    load(1, 8'h11, 1'b0); load(1, 8'h22, 1'b0); load(1, 8'h33, 1'b1);
    load(2, 8'h44, 1'b1);
    build_exp(); drive();
    drain(200);

    // timeout: move pointer to 3, then req3 sends a non-last byte and goes quiet
    load(2, 8'h5A, 1'b1); build_exp(); drive(); drain(100);
    load(3, 8'h3C, 1'b0); load(0, 8'hC0, 1'b1);
    expq.push_back({2'd3, 8'h3C}); expq.push_back({2'd0, 8'hC0});
    m_ptr = 1;
    drive();
    e0 = evt_cnt;
    n = 0;
    while (expq.size() != 1 && n < 100) begin step(); n++; end
    chk("tmo_first_byte", expq.size(), 1);
    s3 = last_start;
    n = 0;
    while (evt_cnt == e0 && n < 200) begin step(); n++; end
    chk("tmo_evt", evt_cnt, e0 + 1);
    chk("tmo_latency", evt_cyc - s3, frame + 18);
    chk("tmo_gact", smp_gact, 1'b0);
    drain(100);
    chk("tmo_single", evt_cnt, e0 + 1);

    // reset while the transmitter is busy with a packet's first byte
    load(2, 8'h01, 1'b0); load(2, 8'h02, 1'b0); load(2, 8'h03, 1'b1);
    build_exp(); drive();
    n = 0;
    while (expq.size() != 2 && n < 100) begin step(); n++; end
    chk("rst_mid_start", expq.size(), 2);
    reset = 1'b1;
    for (int i = 0; i < NR; i++) hd[i] = tl[i];
    drive();
    step();
    reset = 1'b0;
    expq.delete(); m_ptr = 0; hs_prev = 1'b0; rdy_cnt = 0;
    step();
    chk("rstm_start", smp_start, 1'b0);
    chk("rstm_data", smp_data, 8'h00);
    chk("rstm_gact", smp_gact, 1'b0);
    chk("rstm_gid", smp_gid, 2'd0);
    chk("rstm_ready", smp_ready, 4'b0000);
    // fairness from pointer 0, busy still high from the unrecalled byte
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < NR; i++) load(i, 8'(8'h80 + 16*r + i), 1'b1);
    build_exp(); drive();
    step();
    step();
    chk("rstm_grant0", smp_gid, 2'd0);
    chk("rstm_gact1", smp_gact, 1'b1);
    drain(400);

    // randomized packets and frame lengths
    for (int rnd = 0; rnd < 8; rnd++) begin
      e0 = evt_cnt;
      frame = $urandom_range(3, 12);
      last_start = -1;
      nb = 0;
      for (int i = 0; i < NR; i++) begin
        int np = $urandom_range(0, 3);
        for (int p = 0; p < np; p++) begin
          int len = $urandom_range(1, 4);
          for (int b = 0; b < len; b++) begin
            load(i, 8'($urandom), b == len - 1);
            nb++;
          end
        end
      end
      build_exp(); drive();
      drain(nb * (frame + 8) + 50);
      chk("rnd_no_tmo", evt_cnt, e0);
      chk("rnd_exp_empty", expq.size(), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
